// File: rtl/player_sprite_renderer_pkg.sv
// Shared constants, types, palette and ROM address helper for the player sprite renderer.
package player_sprite_renderer_pkg;

    localparam int unsigned SPR_W      = 20;
    localparam int unsigned SPR_H      = 40;
    localparam int unsigned NUM_FRAMES = 4;
    localparam int unsigned ANIM_DIV   = 6;
    localparam int unsigned ADDR_W     = 12;
    localparam int unsigned X_RESET    = 80;
    localparam int unsigned Y_RESET    = 378;
    localparam int unsigned COORD_W    = 10;
    localparam int unsigned REL_W      = COORD_W + 1;
    localparam int unsigned RGB_W      = 24;
    localparam int unsigned FRAME_W    = $clog2(NUM_FRAMES);
    localparam int unsigned CNT_W      = $clog2(ANIM_DIV);
    localparam int unsigned COL_W      = $clog2(SPR_W);
    localparam int unsigned ROW_W      = $clog2(SPR_H);

    typedef logic [3:0]         pal_idx_t;
    typedef logic [FRAME_W-1:0] frame_t;
    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [ADDR_W-1:0]  rom_addr_t;
    typedef logic [RGB_W-1:0]   rgb_t;

    // Index 0 is transparent; its colour is never shown.
    localparam rgb_t PALETTE [16] = '{
        24'h000000, 24'hF8D8B0, 24'hE04020, 24'h2040C0,
        24'h402010, 24'hFFD000, 24'h101010, 24'hFFFFFF,
        24'hA0A0A0, 24'h00A000, 24'h804000, 24'hC08040,
        24'hFF8080, 24'h0080FF, 24'h606060, 24'hFF00FF
    };

    // frame*800 + row*20 + col, constant multiplies written as shift-add (SPR_W=20, SPR_H=40).
    function automatic rom_addr_t sprite_addr(input frame_t frame,
                                              input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
        rom_addr_t a_f;
        rom_addr_t a_r;
        rom_addr_t a_c;
        a_f = ADDR_W'(frame);
        a_r = ADDR_W'(row);
        a_c = ADDR_W'(col);
        return (a_f << 9) + (a_f << 8) + (a_f << 5) + (a_r << 4) + (a_r << 2) + a_c;
    endfunction

endpackage

// File: rtl/player_sprite_renderer_if.sv
// Video-side bundle between the pixel source / sprite ROM and the sprite renderer.
interface player_sprite_renderer_if;
    import player_sprite_renderer_pkg::*;

    logic      vs;
    coord_t    DrawX;
    coord_t    DrawY;
    coord_t    BallX;
    coord_t    BallY;
    rom_addr_t rom_addr;
    pal_idx_t  rom_q;
    logic      sprite_on;
    rgb_t      sprite_rgb;
    logic      facing_left;
    coord_t    prev_x;

    modport slave (
        input  vs, DrawX, DrawY, BallX, BallY, rom_q,
        output rom_addr, sprite_on, sprite_rgb, facing_left, prev_x
    );

    modport master (
        output vs, DrawX, DrawY, BallX, BallY, rom_q,
        input  rom_addr, sprite_on, sprite_rgb, facing_left, prev_x
    );

endinterface

// File: rtl/player_sprite_renderer_frame_ctrl.sv
// Per-frame state: vsync edge detect, latched player position, facing and walk-cycle frame.
module player_sprite_renderer_frame_ctrl
    import player_sprite_renderer_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   vs,
    input  coord_t ball_x,
    input  coord_t ball_y,
    output coord_t lat_x,
    output coord_t lat_y,
    output coord_t prev_x,
    output frame_t frame_idx,
    output logic   facing_left
);

    logic             vs_d;
    logic [CNT_W-1:0] move_cnt;
    logic             vs_fall;

    assign vs_fall = vs_d & ~vs;

    // Position and animation update only on the vsync falling edge so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d        <= 1'b1;
            lat_x       <= COORD_W'(X_RESET);
            lat_y       <= COORD_W'(Y_RESET);
            prev_x      <= COORD_W'(X_RESET);
            frame_idx   <= '0;
            move_cnt    <= '0;
            facing_left <= 1'b0;
        end else begin
            vs_d <= vs;
            if (vs_fall) begin
                lat_x  <= ball_x;
                lat_y  <= ball_y;
                prev_x <= lat_x;
                if (ball_x > lat_x) begin
                    facing_left <= 1'b0;
                end else if (ball_x < lat_x) begin
                    facing_left <= 1'b1;
                end
                if (ball_x == lat_x) begin
                    frame_idx <= '0;
                    move_cnt  <= '0;
                end else if (move_cnt == CNT_W'(ANIM_DIV - 1)) begin
                    move_cnt  <= '0;
                    frame_idx <= (frame_idx == FRAME_W'(NUM_FRAMES - 1)) ? '0
                                                                         : frame_idx + 1'b1;
                end else begin
                    move_cnt <= move_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/player_sprite_renderer.sv
// Player sprite overlay: 3-stage pixel pipeline (hit-test -> ROM address -> palette/transparency).
module player_sprite_renderer
    import player_sprite_renderer_pkg::*;
(
    input  logic                      Clk,
    input  logic                      Reset_n,
    player_sprite_renderer_if.slave   bus
);

    coord_t lat_x;
    coord_t lat_y;
    frame_t frame_idx;

    player_sprite_renderer_frame_ctrl u_ctrl (
        .clk         (Clk),
        .rst_n       (Reset_n),
        .vs          (bus.vs),
        .ball_x      (bus.BallX),
        .ball_y      (bus.BallY),
        .lat_x       (lat_x),
        .lat_y       (lat_y),
        .prev_x      (bus.prev_x),
        .frame_idx   (frame_idx),
        .facing_left (bus.facing_left)
    );

    logic signed [REL_W-1:0] rel_x;
    logic signed [REL_W-1:0] rel_y;
    logic [COL_W-1:0]        col;
    logic                    hit;
    rom_addr_t               addr;
    logic                    hit_s1;
    logic                    hit_s2;
    logic                    opaque;

    // Signed relative coordinates stop an off-screen sprite from aliasing to the far edge.
    always_comb begin
        rel_x = $signed({1'b0, bus.DrawX}) - $signed({1'b0, lat_x})
              + $signed(REL_W'(SPR_W / 2));
        rel_y = $signed({1'b0, bus.DrawY}) - $signed({1'b0, lat_y})
              + $signed(REL_W'(SPR_H / 2));
        hit   = !rel_x[REL_W-1] && (rel_x < $signed(REL_W'(SPR_W)))
             && !rel_y[REL_W-1] && (rel_y < $signed(REL_W'(SPR_H)));
        col   = bus.facing_left ? COL_W'(SPR_W - 1) - rel_x[COL_W-1:0] : rel_x[COL_W-1:0];
        addr  = sprite_addr(frame_idx, rel_y[ROW_W-1:0], col);
    end

    assign opaque = hit_s2 && (bus.rom_q != '0);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hit_s1         <= 1'b0;
            hit_s2         <= 1'b0;
            bus.rom_addr   <= '0;
            bus.sprite_on  <= 1'b0;
            bus.sprite_rgb <= '0;
        end else begin
            hit_s1 <= hit;
            if (hit) begin
                bus.rom_addr <= addr;
            end
            hit_s2         <= hit_s1;
            bus.sprite_on  <= opaque;
            bus.sprite_rgb <= opaque ? PALETTE[bus.rom_q] : '0;
        end
    end

endmodule

// File: tb/tb_player_sprite_renderer.sv
// Directed self-checking bench for player_sprite_renderer with a registered sprite ROM model.
module tb_player_sprite_renderer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic [3:0] rom_mem [4096];

    player_sprite_renderer_if bus ();

    player_sprite_renderer dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Sprite ROM: data valid one clock after the address
    always @(posedge clk) bus.rom_q <= rom_mem[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vsync_pulse();
        bus.vs = 1'b0;
        tick(1);
        bus.vs = 1'b1;
        tick(1);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        clk       = 1'b0;
        rst_n     = 1'b0;
        bus.vs    = 1'b1;
        bus.DrawX = 10'd0;
        bus.DrawY = 10'd0;
        bus.BallX = 10'd80;
        bus.BallY = 10'd378;
        bus.rom_q = 4'd0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 4'd7;
        rom_mem[410] = 4'd5;

        #12;
        check("rst_rom_addr",   32'(bus.rom_addr),    32'd0);
        check("rst_sprite_on",  32'(bus.sprite_on),   32'd0);
        check("rst_rgb",        32'(bus.sprite_rgb),  32'd0);
        check("rst_facing",     32'(bus.facing_left), 32'd0);
        check("rst_prev_x",     32'(bus.prev_x),      32'd80);
        rst_n = 1'b1;
        tick(1);

        // 1: centre pixel at spawn position
        bus.DrawX = 10'd80;
        bus.DrawY = 10'd378;
        tick(1);
        check("t1_rom_addr", 32'(bus.rom_addr), 32'd410);
        tick(2);
        check("t1_sprite_on", 32'(bus.sprite_on),  32'd1);
        check("t1_rgb",       32'(bus.sprite_rgb), 32'hFFD000);

        // 2: just left of the box
        bus.DrawX = 10'd69;
        tick(1);
        check("t2_rom_addr_hold", 32'(bus.rom_addr), 32'd410);
        tick(2);
        check("t2_sprite_on", 32'(bus.sprite_on),  32'd0);
        check("t2_rgb",       32'(bus.sprite_rgb), 32'd0);

        // 3: transparent pixel followed by opaque pixel
        rom_mem[410] = 4'd0;
        rom_mem[411] = 4'd1;
        bus.DrawX = 10'd80;
        tick(1);
        bus.DrawX = 10'd81;
        tick(1);
        bus.DrawX = 10'd69;
        tick(1);
        check("t3_transparent", 32'(bus.sprite_on), 32'd0);
        tick(1);
        check("t3_opaque_on",  32'(bus.sprite_on),  32'd1);
        check("t3_opaque_rgb", 32'(bus.sprite_rgb), 32'hF8D8B0);
        rom_mem[410] = 4'd5;

        // 4: walk right 12 frames, then step left
        for (int i = 1; i <= 12; i++) begin
            bus.BallX = 10'(80 + i);
            vsync_pulse();
            if (i == 1) check("t4_prev_x", 32'(bus.prev_x), 32'd80);
            if (i == 6) begin
                check("t4_cnt_wrap6", 32'(dut.u_ctrl.move_cnt), 32'd0);
                bus.DrawX = 10'(80 + i);
                tick(1);
                check("t4_frame1_addr", 32'(bus.rom_addr), 32'd1210);
            end
        end
        bus.DrawX = 10'd92;
        tick(1);
        check("t4_frame2_addr", 32'(bus.rom_addr),    32'd2010);
        check("t4_facing_r",    32'(bus.facing_left), 32'd0);
        bus.BallX = 10'd91;
        vsync_pulse();
        check("t4_facing_l", 32'(bus.facing_left), 32'd1);
        bus.DrawX = 10'd81;
        tick(1);
        check("t4_mirror_col19", 32'(bus.rom_addr), 32'd2019);

        // 5: hold position for one frame -> idle pose
        vsync_pulse();
        check("t5_move_cnt", 32'(dut.u_ctrl.move_cnt), 32'd0);
        check("t5_facing",   32'(bus.facing_left),     32'd1);
        tick(1);
        check("t5_idle_addr", 32'(bus.rom_addr), 32'd419);

        // 6: sprite clipped at the left screen edge
        bus.BallX = 10'd5;
        vsync_pulse();
        bus.DrawX = 10'd0;
        tick(1);
        check("t6_edge_addr", 32'(bus.rom_addr), 32'd414);
        tick(2);
        check("t6_edge_on", 32'(bus.sprite_on), 32'd1);
        for (int x = 1015; x <= 1023; x++) begin
            bus.DrawX = 10'(x);
            tick(3);
            check($sformatf("t6_wrap_%0d", x), 32'(bus.sprite_on), 32'd0);
        end
        check("t6_wrap_addr_hold", 32'(bus.rom_addr), 32'd414);

        // 6: reset pulse mid-line
        bus.DrawX = 10'd0;
        tick(3);
        check("t6_pre_rst_on", 32'(bus.sprite_on), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_on",     32'(bus.sprite_on),   32'd0);
        check("t6_rst_rgb",    32'(bus.sprite_rgb),  32'd0);
        check("t6_rst_prev_x", 32'(bus.prev_x),      32'd80);
        check("t6_rst_facing", 32'(bus.facing_left), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.DrawX = 10'd80;
        tick(1);
        check("t6_post_rst_addr", 32'(bus.rom_addr), 32'd410);
        tick(2);
        check("t6_post_rst_on",  32'(bus.sprite_on),  32'd1);
        check("t6_post_rst_rgb", 32'(bus.sprite_rgb), 32'hFFD000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
